data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Arbitrates LSU read/write requests from many consumers onto a smaller set of data-memory
// channels; each channel owns at most one consumer at a time and relays one transaction.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | channel free, may be granted a pending consumer
// READ_WAIT   | mem_read_valid driven, waiting for mem_read_ready
// WRITE_WAIT  | mem_write_valid driven, waiting for mem_write_ready
// READ_RELAY  | consumer_read_ready held until the consumer drops read_valid
// WRITE_RELAY | consumer_write_ready held until the consumer drops write_valid
module data_mem_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      READ_WAIT   = 3'd1,
      WRITE_WAIT  = 3'd2,
      READ_RELAY  = 3'd3,
      WRITE_RELAY = 3'd4
   } state_t;

   state_t                             state_q [NUM_CHANNELS];
   state_t                             state_d [NUM_CHANNELS];
   logic [CW-1:0]                      owner_q [NUM_CHANNELS];
   logic [CW-1:0]                      owner_d [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0]           claimed_q, claimed_d;
   logic [CW-1:0]                      rr_q, rr_d;
   logic [NUM_CONSUMERS-1:0]           rd_ready_q, rd_ready_d;
   logic [NUM_CONSUMERS-1:0]           wr_ready_q, wr_ready_d;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;
   logic [NUM_CHANNELS-1:0]            mrv_q, mrv_d, mwv_q, mwv_d;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]  mra_q, mra_d, mwa_q, mwa_d;
   logic [NUM_CHANNELS*DATA_BITS-1:0]  mwd_q, mwd_d;

   logic [NUM_CONSUMERS-1:0]           pending;
   logic [NUM_CONSUMERS-1:0]           taken;
   logic                               found;
   logic                               granted;
   int                                 sel;
   int                                 idx;
   int                                 last_grant;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      claimed_d  = claimed_q;
      rr_d       = rr_q;
      rd_ready_d = rd_ready_q;
      wr_ready_d = wr_ready_q;
      rd_data_d  = rd_data_q;
      mrv_d      = mrv_q;
      mra_d      = mra_q;
      mwv_d      = mwv_q;
      mwa_d      = mwa_q;
      mwd_d      = mwd_q;
      pending    = (consumer_read_valid | consumer_write_valid) & ~claimed_q;
      taken      = '0;
      found      = 1'b0;
      granted    = 1'b0;
      sel        = 0;
      idx        = 0;
      last_grant = 0;

      for (int c = 0; c < NUM_CHANNELS; c++) begin
         case (state_q[c])
            IDLE: begin
               // Lower channels claim first; taken stops two channels picking one consumer.
               found = 1'b0;
               sel   = 0;
               for (int k = 0; k < NUM_CONSUMERS; k++) begin
                  idx = (int'(rr_q) + k) % NUM_CONSUMERS;
                  if (!found && pending[idx] && !taken[idx]) begin
                     found = 1'b1;
                     sel   = idx;
                  end
               end
               if (found) begin
                  taken[sel]     = 1'b1;
                  claimed_d[sel] = 1'b1;
                  owner_d[c]     = CW'(sel);
                  granted        = 1'b1;
                  last_grant     = sel;
                  if (consumer_read_valid[sel]) begin
                     state_d[c] = READ_WAIT;
                     mrv_d[c]   = 1'b1;
                     mra_d[c*ADDR_BITS +: ADDR_BITS] =
                        consumer_read_address[sel*ADDR_BITS +: ADDR_BITS];
                  end else begin
                     state_d[c] = WRITE_WAIT;
                     mwv_d[c]   = 1'b1;
                     mwa_d[c*ADDR_BITS +: ADDR_BITS] =
                        consumer_write_address[sel*ADDR_BITS +: ADDR_BITS];
                     mwd_d[c*DATA_BITS +: DATA_BITS] =
                        consumer_write_data[sel*DATA_BITS +: DATA_BITS];
                  end
               end
            end
            READ_WAIT: begin
               if (mem_read_ready[c]) begin
                  mrv_d[c] = 1'b0;
                  rd_data_d[owner_q[c]*DATA_BITS +: DATA_BITS] =
                     mem_read_data[c*DATA_BITS +: DATA_BITS];
                  rd_ready_d[owner_q[c]] = 1'b1;
                  state_d[c] = READ_RELAY;
               end
            end
            WRITE_WAIT: begin
               if (mem_write_ready[c]) begin
                  mwv_d[c]               = 1'b0;
                  wr_ready_d[owner_q[c]] = 1'b1;
                  state_d[c]             = WRITE_RELAY;
               end
            end
            READ_RELAY: begin
               if (!consumer_read_valid[owner_q[c]]) begin
                  rd_ready_d[owner_q[c]] = 1'b0;
                  claimed_d[owner_q[c]]  = 1'b0;
                  state_d[c]             = IDLE;
               end
            end
            WRITE_RELAY: begin
               if (!consumer_write_valid[owner_q[c]]) begin
                  wr_ready_d[owner_q[c]] = 1'b0;
                  claimed_d[owner_q[c]]  = 1'b0;
                  state_d[c]             = IDLE;
               end
            end
            default: state_d[c] = IDLE;
         endcase
      end

      if (granted) begin
         rr_d = CW'((last_grant + 1) % NUM_CONSUMERS);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= IDLE;
            owner_q[c] <= '0;
         end
         claimed_q  <= '0;
         rr_q       <= '0;
         rd_ready_q <= '0;
         wr_ready_q <= '0;
         rd_data_q  <= '0;
         mrv_q      <= '0;
         mra_q      <= '0;
         mwv_q      <= '0;
         mwa_q      <= '0;
         mwd_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         claimed_q  <= claimed_d;
         rr_q       <= rr_d;
         rd_ready_q <= rd_ready_d;
         wr_ready_q <= wr_ready_d;
         rd_data_q  <= rd_data_d;
         mrv_q      <= mrv_d;
         mra_q      <= mra_d;
         mwv_q      <= mwv_d;
         mwa_q      <= mwa_d;
         mwd_q      <= mwd_d;
      end
   end

   assign consumer_read_ready  = rd_ready_q;
   assign consumer_read_data   = rd_data_q;
   assign consumer_write_ready = wr_ready_q;
   assign mem_read_valid       = mrv_q;
   assign mem_read_address     = mra_q;
   assign mem_write_valid      = mwv_q;
   assign mem_write_address    = mwa_q;
   assign mem_write_data       = mwd_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a 4-channel instance for most cases and a
// 1-channel instance for the round-robin fairness case.
module tb_data_mem_arbiter;
   localparam int NC = 8;
   localparam int NH = 4;
   localparam int AW = 8;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NC-1:0]    rv, wv, crr, cwr;
   logic [NC*AW-1:0] ra, wa;
   logic [NC*DW-1:0] crd, wd;
   logic [NH-1:0]    mrv, mrr, mwv, mwr;
   logic [NH*AW-1:0] mra, mwa;
   logic [NH*DW-1:0] mrd, mwd;

   logic [NC-1:0]    o_rv, o_crr, o_cwr;
   logic [NC*AW-1:0] o_ra;
   logic [NC*DW-1:0] o_crd;
   logic [0:0]       o_mrv, o_mrr, o_mwv, o_mwr;
   logic [AW-1:0]    o_mra, o_mwa;
   logic [DW-1:0]    o_mrd, o_mwd;

   data_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NH)) dut (
      .clk(clk), .reset(reset),
      .consumer_read_valid(rv), .consumer_read_address(ra),
      .consumer_read_ready(crr), .consumer_read_data(crd),
      .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd),
      .consumer_write_ready(cwr),
      .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
      .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
      .mem_write_ready(mwr)
   );

   data_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) u_one (
      .clk(clk), .reset(reset),
      .consumer_read_valid(o_rv), .consumer_read_address(o_ra),
      .consumer_read_ready(o_crr), .consumer_read_data(o_crd),
      .consumer_write_valid('0), .consumer_write_address('0), .consumer_write_data('0),
      .consumer_write_ready(o_cwr),
      .mem_read_valid(o_mrv), .mem_read_address(o_mra), .mem_read_ready(o_mrr), .mem_read_data(o_mrd),
      .mem_write_valid(o_mwv), .mem_write_address(o_mwa), .mem_write_data(o_mwd),
      .mem_write_ready(o_mwr)
   );

   typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

   logic [7:0] mem [256];
   logic [7:0] exp_rd [NC][$];
   logic [7:0] exp_ch [NH][$];
   logic [7:0] exp_one [$];
   int         exp_wr [NC][$];
   wr_t        exp_mw [$];
   logic [7:0] rd_addr_of [NC];
   logic [7:0] o_addr [NC];
   int         reissue [NC];
   int         o_reissue [NC];
   int         hold [NC];
   int         issue_cyc [NC];
   int         last_rd_cyc [NC];
   int         lat_r [NH];
   int         lat_w [NH];
   int         o_lat;
   logic [NH-1:0] stall;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [NH-1:0] pv_mrv = '0, pv_mwv = '0;
   logic [NC-1:0] pv_crr = '0, pv_cwr = '0, pv_ocrr = '0;
   logic [0:0]    pv_omrv = '0;
   logic [NC-1:0] smp_rv = '0, smp_wv = '0;
   logic [7:0]    cur_rd [NC];

   always @(posedge clk) begin
      smp_rv <= rv;
      smp_wv <= wv;
   end

   always @(negedge clk) begin
      for (int c = 0; c < NH; c++) begin
         if (mrv[c] && !pv_mrv[c] && exp_ch[c].size() > 0)
            chk($sformatf("ch%0d_read_addr", c), 64'(mra[c*AW +: AW]), 64'(exp_ch[c].pop_front()));
         if (mwv[c] && !pv_mwv[c]) begin
            if (exp_mw.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_mem_write ch%0d: got valid=1, expected none", c);
            end else begin
               chk($sformatf("ch%0d_write_addr_data", c),
                   64'({mwa[c*AW +: AW], mwd[c*DW +: DW]}), 64'(exp_mw.pop_front()));
            end
         end
      end
      for (int i = 0; i < NC; i++) begin
         if (crr[i] && !pv_crr[i]) begin
            if (exp_rd[i].size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read_ready c%0d: got ready=1, expected none", i);
            end else begin
               cur_rd[i] = exp_rd[i].pop_front();
               last_rd_cyc[i] = cyc;
               chk($sformatf("c%0d_read_data", i), 64'(crd[i*DW +: DW]), 64'(cur_rd[i]));
            end
         end else if (crr[i]) begin
            chk($sformatf("c%0d_read_data_held", i), 64'(crd[i*DW +: DW]), 64'(cur_rd[i]));
         end
         if (pv_crr[i])
            chk($sformatf("c%0d_read_ready_follows_valid", i), 64'(crr[i]), 64'(smp_rv[i]));
         if (cwr[i] && !pv_cwr[i]) begin
            if (exp_wr[i].size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write_ready c%0d: got ready=1, expected none", i);
            end else begin
               void'(exp_wr[i].pop_front());
               chk($sformatf("c%0d_reads_done_before_write", i), 64'(exp_rd[i].size()), 64'd0);
            end
         end
         if (pv_cwr[i])
            chk($sformatf("c%0d_write_ready_follows_valid", i), 64'(cwr[i]), 64'(smp_wv[i]));
         if (o_crr[i] && !pv_ocrr[i])
            chk($sformatf("one_c%0d_read_data", i), 64'(o_crd[i*DW +: DW]), 64'(mem[o_addr[i]]));
      end
      if (o_mrv[0] && !pv_omrv[0]) begin
         if (exp_one.size() == 0) begin
            checks++; errors++;
            $display("FAIL one_unexpected_grant: got addr %0h, expected none", o_mra);
         end else begin
            chk("one_grant_order", 64'(o_mra), 64'(exp_one.pop_front()));
         end
      end
      pv_mrv  = mrv;
      pv_mwv  = mwv;
      pv_crr  = crr;
      pv_cwr  = cwr;
      pv_ocrr = o_crr;
      pv_omrv = o_mrv;
   end

   // ---------------- stimulus side: memory model and consumers ----------------
   task automatic raise_read(input int i);
      rv[i] = 1'b1;
      ra[i*AW +: AW] = rd_addr_of[i];
      exp_rd[i].push_back(mem[rd_addr_of[i]]);
      issue_cyc[i] = cyc;
      if (reissue[i] > 0) reissue[i]--;
   endtask

   task automatic issue_write(input int i, input logic [7:0] a, input logic [7:0] d);
      wv[i] = 1'b1;
      wa[i*AW +: AW] = a;
      wd[i*DW +: DW] = d;
      exp_mw.push_back({a, d});
      exp_wr[i].push_back(1);
   endtask

   // Memory acknowledges one cycle after it first samples a request.
   task automatic tick();
      @(negedge clk);
      for (int c = 0; c < NH; c++) begin
         if (!stall[c] && mrv[c] && !mrr[c]) begin
            lat_r[c]++;
            if (lat_r[c] >= 2) begin
               mrr[c] = 1'b1;
               mrd[c*DW +: DW] = mem[mra[c*AW +: AW]];
               lat_r[c] = 0;
            end
         end else begin
            mrr[c] = 1'b0;
            lat_r[c] = 0;
         end
         if (mwv[c] && !mwr[c]) begin
            lat_w[c]++;
            if (lat_w[c] >= 2) begin
               mwr[c] = 1'b1;
               mem[mwa[c*AW +: AW]] = mwd[c*DW +: DW];
               lat_w[c] = 0;
            end
         end else begin
            mwr[c] = 1'b0;
            lat_w[c] = 0;
         end
      end
      if (o_mrv[0] && !o_mrr[0]) begin
         o_lat++;
         if (o_lat >= 2) begin
            o_mrr[0] = 1'b1;
            o_mrd = mem[o_mra];
            o_lat = 0;
         end
      end else begin
         o_mrr[0] = 1'b0;
         o_lat = 0;
      end
      for (int i = 0; i < NC; i++) begin
         if (rv[i] && crr[i]) begin
            if (hold[i] > 0) hold[i]--;
            else rv[i] = 1'b0;
         end else if (!rv[i] && reissue[i] > 0) begin
            raise_read(i);
         end
         if (wv[i] && cwr[i]) wv[i] = 1'b0;
         if (o_rv[i] && o_crr[i]) begin
            o_rv[i] = 1'b0;
         end else if (!o_rv[i] && o_reissue[i] > 0) begin
            o_rv[i] = 1'b1;
            o_ra[i*AW +: AW] = o_addr[i];
            o_reissue[i]--;
         end
      end
   endtask

   function automatic bit busy();
      bit b;
      b = (rv != '0) || (wv != '0) || (o_rv != '0) || (exp_mw.size() != 0) || (exp_one.size() != 0);
      for (int i = 0; i < NC; i++)
         if (exp_rd[i].size() != 0 || exp_wr[i].size() != 0 || reissue[i] != 0 || o_reissue[i] != 0)
            b = 1'b1;
      for (int c = 0; c < NH; c++)
         if (exp_ch[c].size() != 0) b = 1'b1;
      return b;
   endfunction

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (busy() && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (busy()) begin
         errors++;
         $display("FAIL wait_%s: still busy after %0d cycles, expected idle", name, n);
      end
      repeat (3) tick();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      rv = '0;
      wv = '0;
      o_rv = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_consumer_read_ready"},  64'(crr), 64'd0);
      chk({tag, "_consumer_read_data"},   crd, 64'd0);
      chk({tag, "_consumer_write_ready"}, 64'(cwr), 64'd0);
      chk({tag, "_mem_read_valid"},       64'(mrv), 64'd0);
      chk({tag, "_mem_read_address"},     64'(mra), 64'd0);
      chk({tag, "_mem_write_valid"},      64'(mwv), 64'd0);
      chk({tag, "_mem_write_address"},    64'(mwa), 64'd0);
      chk({tag, "_mem_write_data"},       64'(mwd), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
      mrr = '0; mrd = '0; mwr = '0;
      o_rv = '0; o_ra = '0; o_mrr = '0; o_mrd = '0; o_mwr = '0; o_lat = 0;
      stall = '0;
      for (int a = 0; a < 256; a++) mem[a] = 8'(a * 7 + 3);
      mem[8'h05] = 8'h2A;
      for (int i = 0; i < NC; i++) begin
         reissue[i] = 0; o_reissue[i] = 0; hold[i] = 0;
         issue_cyc[i] = 0; last_rd_cyc[i] = 0; rd_addr_of[i] = '0; o_addr[i] = '0;
      end
      for (int c = 0; c < NH; c++) begin
         lat_r[c] = 0; lat_w[c] = 0;
      end

      apply_reset();
      check_zero("reset");

      // single read, held two extra cycles after ready
      rd_addr_of[0] = 8'h05;
      hold[0] = 2;
      exp_ch[0].push_back(8'h05);
      raise_read(0);
      wait_done("single_read", 100);
      chk("read_latency_edges", 64'(last_rd_cyc[0] - issue_cyc[0]), 64'd3);

      // eight simultaneous reads over four channels
      apply_reset();
      for (int i = 0; i < NC; i++) begin
         rd_addr_of[i] = 8'h80 + 8'(i);
         exp_ch[i % NH].push_back(8'h80 + 8'(i));
      end
      for (int i = 0; i < NC; i++) raise_read(i);
      wait_done("eight_reads", 200);

      // fairness on a single channel: 0 and 5 alternate
      apply_reset();
      o_addr[0] = 8'h40;
      o_addr[5] = 8'h55;
      o_reissue[0] = 3;
      o_reissue[5] = 3;
      for (int k = 0; k < 3; k++) begin
         exp_one.push_back(8'h40);
         exp_one.push_back(8'h55);
      end
      wait_done("fairness", 300);

      // single write
      apply_reset();
      issue_write(2, 8'h12, 8'h11);
      wait_done("single_write", 100);
      chk("mem_after_write", 64'(mem[8'h12]), 64'h11);

      // read and write together on one consumer: read (old data) first
      apply_reset();
      rd_addr_of[4] = 8'h12;
      raise_read(4);
      issue_write(4, 8'h12, 8'h33);
      wait_done("read_then_write", 200);
      chk("mem_after_rw", 64'(mem[8'h12]), 64'h33);
      raise_read(4);
      wait_done("read_after_write", 100);

      // reset while channels wait on a stalled memory
      apply_reset();
      stall = 4'b0011;
      rd_addr_of[0] = 8'h20;
      rd_addr_of[1] = 8'h21;
      raise_read(0);
      raise_read(1);
      repeat (6) tick();
      chk("stalled_read_valid", 64'(mrv), 64'h3);
      reset = 1'b1;
      rv = '0;
      exp_rd[0].delete();
      exp_rd[1].delete();
      tick();
      check_zero("mid_reset");
      reset = 1'b0;
      stall = '0;
      rd_addr_of[1] = 8'h31;
      rd_addr_of[6] = 8'h36;
      exp_ch[0].push_back(8'h31);
      exp_ch[1].push_back(8'h36);
      raise_read(1);
      raise_read(6);
      wait_done("after_reset", 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
